// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding imem requests, holds IR and splits fields.
// Optional macro IF_DELAY_SLOT_EN delivers one delay-slot instruction before a redirect target.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_fetch_q, pc_fetch_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] redir_tgt;
    logic        hold_req;
`ifdef IF_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    // Handshake: imem_req stays high until imem_ack; an ack counts only while imem_req is high.
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign hold_req  = (state_q == HOLD) && id_ready;
    assign imem_req  = (state_q == REQ) || hold_req;
    assign imem_addr = (state_q == REQ) ? req_addr_q : pc_fetch_q;

    assign if_valid  = if_valid_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign pc_plus4  = ir_pc_q + 32'd4;
    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign imm16     = ir_q[15:0];
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        req_addr_d = req_addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
`ifdef IF_DELAY_SLOT_EN
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
`endif
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = pc_fetch_q;
            end
            REQ: begin
                if (imem_ack) begin
                    if (kill_q) begin
                        kill_d     = 1'b0;
                        req_addr_d = pc_fetch_q;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = req_addr_q;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
`ifdef IF_DELAY_SLOT_EN
                        // A pending target takes over once the slot word lands in IR.
                        pc_fetch_d = pend_q ? pend_pc_q : req_addr_q + PC_STEP;
                        pend_d     = 1'b0;
`else
                        pc_fetch_d = req_addr_q + PC_STEP;
`endif
                    end
                end
            end
            HOLD: begin
                if (id_ready) begin
                    if (imem_ack) begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = pc_fetch_q;
                        pc_fetch_d = pc_fetch_q + PC_STEP;
                    end else begin
                        if_valid_d = 1'b0;
                        req_addr_d = pc_fetch_q;
                        state_d    = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
`ifdef IF_DELAY_SLOT_EN
            case (state_q)
                IDLE: begin
                    pc_fetch_d = redir_tgt;
                    req_addr_d = redir_tgt;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_fetch_d = redir_tgt;
                        pend_d     = 1'b0;
                    end else begin
                        pend_d     = 1'b1;
                        pend_pc_d  = redir_tgt;
                    end
                end
                HOLD: begin
                    // Slot is either the unconsumed IR word or the word acked this cycle.
                    if (!id_ready || imem_ack) begin
                        pc_fetch_d = redir_tgt;
                    end else begin
                        pend_d     = 1'b1;
                        pend_pc_d  = redir_tgt;
                    end
                end
                default: ;
            endcase
`else
            pc_fetch_d = redir_tgt;
            if_valid_d = 1'b0;
            case (state_q)
                IDLE: req_addr_d = redir_tgt;
                REQ: begin
                    if (imem_ack) begin
                        kill_d     = 1'b0;
                        req_addr_d = redir_tgt;
                        ir_d       = ir_q;
                        ir_pc_d    = ir_pc_q;
                        state_d    = REQ;
                    end else if (!kill_q) begin
                        kill_d     = 1'b1;
                    end
                end
                HOLD: begin
                    req_addr_d = redir_tgt;
                    ir_d       = ir_q;
                    ir_pc_d    = ir_pc_q;
                    state_d    = REQ;
                end
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_fetch_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            ir_q       <= 32'd0;
            ir_pc_q    <= 32'd0;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            req_addr_q <= req_addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
        end
    end

`ifdef IF_DELAY_SLOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: zero-wait streaming, stalls, field split, redirects, wrap and reset.
module tb_ifetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] ir, ir_pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic        auto_ack, man_ack, ovr_en;
    logic [31:0] ovr_data;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {16'h8C22, a[15:0]};
    endfunction

    // Memory model: zero-wait (ack follows req) or manual ack; data derived from the address.
    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = ovr_en ? ovr_data : pat(imem_addr);

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .ir(ir), .ir_pc(ir_pc), .pc_plus4(pc_plus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
        .dbg_state(dbg_state)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
        auto_ack = 1'b1; man_ack = 1'b0; ovr_en = 1'b0; ovr_data = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_valid); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h exp 0", ir); end
        checks++; if (ir_pc !== 32'd0) begin errors++; $display("FAIL rst_ir_pc: got %h exp 0", ir_pc); end
        checks++; if (opcode !== 6'd0 || imm16 !== 16'd0) begin errors++; $display("FAIL rst_fields: got %h/%h exp 0/0", opcode, imm16); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req: got %b exp 0", imem_req); end
        next_cycle;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL zw_first_req: got %b/%h exp 1/3000", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b exp 0", if_valid); end
        for (int k = 0; k < 3; k++) begin
            next_cycle;
            #1;
            a = 32'h3000 + 32'(4 * k);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b exp 1", k, if_valid); end
            checks++; if (ir_pc !== a) begin errors++; $display("FAIL zw_ir_pc[%0d]: got %h exp %h", k, ir_pc, a); end
            checks++; if (ir !== pat(a)) begin errors++; $display("FAIL zw_ir[%0d]: got %h exp %h", k, ir, pat(a)); end
            checks++; if (pc_plus4 !== a + 32'd4) begin errors++; $display("FAIL zw_pc_plus4[%0d]: got %h exp %h", k, pc_plus4, a + 32'd4); end
            checks++; if (imem_addr !== a + 32'd4) begin errors++; $display("FAIL zw_addr[%0d]: got %h exp %h", k, imem_addr, a + 32'd4); end
        end
    endtask

    task automatic test_stall;
        id_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req0: got %b exp 0", imem_req); end
        for (int k = 0; k < 5; k++) begin
            next_cycle;
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || ir_pc !== 32'h3008 || ir !== pat(32'h3008)) begin
                errors++; $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h ir=%h exp 0/1/3008/%h", k, imem_req, if_valid, ir_pc, ir, pat(32'h3008));
            end
        end
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C) begin errors++; $display("FAIL stall_resume_req: got %b/%h exp 1/300c", imem_req, imem_addr); end
        next_cycle;
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'h300C) begin errors++; $display("FAIL stall_resume_ir: got %b/%h exp 1/300c", if_valid, ir_pc); end
    endtask

    task automatic test_lui;
        ovr_en = 1'b1; ovr_data = 32'h3C01_1234;
        next_cycle;
        ovr_en = 1'b0;
        checks++; if (ir !== 32'h3C01_1234 || ir_pc !== 32'h3010) begin errors++; $display("FAIL lui_ir: got %h@%h exp 3c011234@3010", ir, ir_pc); end
        checks++; if (opcode !== 6'h0F || rs !== 5'd0 || rt !== 5'd1) begin errors++; $display("FAIL lui_op_rs_rt: got %h/%0d/%0d exp 0f/0/1", opcode, rs, rt); end
        checks++; if (rd !== 5'd2 || shamt !== 5'd8 || funct !== 6'h34) begin errors++; $display("FAIL lui_rd_sh_fn: got %0d/%0d/%h exp 2/8/34", rd, shamt, funct); end
        checks++; if (imm16 !== 16'h1234) begin errors++; $display("FAIL lui_imm16: got %h exp 1234", imm16); end
        checks++; if (pc_plus4 !== 32'h3014) begin errors++; $display("FAIL lui_pc_plus4: got %h exp 3014", pc_plus4); end
    endtask

    task automatic test_redirect_hold;
        rst = 1'b1;
        repeat (2) next_cycle;
        rst = 1'b0; id_ready = 1'b1; auto_ack = 1'b1;
        repeat (4) next_cycle;
        checks++; if (ir_pc !== 32'h3008 || if_valid !== 1'b1) begin errors++; $display("FAIL rh_setup: got %b/%h exp 1/3008", if_valid, ir_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3203;
        next_cycle;
        redirect_valid = 1'b0;
        #1;
`ifdef IF_DELAY_SLOT_EN
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'h300C) begin errors++; $display("FAIL rh_slot: got %b/%h exp 1/300c", if_valid, ir_pc); end
`else
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rh_flush: got %b exp 0", if_valid); end
`endif
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3200) begin errors++; $display("FAIL rh_target_req: got %b/%h exp 1/3200", imem_req, imem_addr); end
        next_cycle;
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'h3200 || ir !== pat(32'h3200)) begin errors++; $display("FAIL rh_target_ir: got %b/%h/%h exp 1/3200/%h", if_valid, ir_pc, ir, pat(32'h3200)); end
    endtask

    task automatic test_wrap;
        logic found;
        found = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        next_cycle;
        redirect_valid = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (if_valid === 1'b1 && ir_pc === 32'hFFFF_FFFC) found = 1'b1;
            else next_cycle;
        end
        checks++; if (!found) begin errors++; $display("FAIL wrap_reach: got %h exp fffffffc", ir_pc); end
        checks++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_pc_plus4: got %h exp 0", pc_plus4); end
        next_cycle;
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'd0) begin errors++; $display("FAIL wrap_next: got %b/%h exp 1/0", if_valid, ir_pc); end
    endtask

    task automatic test_latency_redirect;
        rst = 1'b1;
        repeat (2) next_cycle;
        rst = 1'b0; id_ready = 1'b1; auto_ack = 1'b1;
        repeat (2) next_cycle;
        auto_ack = 1'b0; man_ack = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL lat_hold_req: got %b/%h exp 1/3004", imem_req, imem_addr); end
        next_cycle;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3004 || dbg_state !== 2'd1) begin errors++; $display("FAIL lat_wait1: got %b/%h/%0d exp 0/3004/1", if_valid, imem_addr, dbg_state); end
        next_cycle;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
        #1;
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL lat_wait2: got %h exp 3004", imem_addr); end
        next_cycle;
        redirect_valid = 1'b0; man_ack = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL lat_wait3: got %b/%h exp 1/3004", imem_req, imem_addr); end
        next_cycle;
        man_ack = 1'b0;
        #1;
`ifdef IF_DELAY_SLOT_EN
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'h3004) begin errors++; $display("FAIL lat_slot: got %b/%h exp 1/3004", if_valid, ir_pc); end
`else
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lat_discard: got %b exp 0", if_valid); end
`endif
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin errors++; $display("FAIL lat_target_req: got %b/%h exp 1/3100", imem_req, imem_addr); end
        man_ack = 1'b1;
        next_cycle;
        man_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || ir_pc !== 32'h3100) begin errors++; $display("FAIL lat_target_ir: got %b/%h exp 1/3100", if_valid, ir_pc); end
    endtask

    task automatic test_reset_mid_req;
        next_cycle;
        #1;
        checks++; if (imem_req !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL mid_in_req: got %b/%0d exp 1/1", imem_req, dbg_state); end
        rst = 1'b1;
        next_cycle;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || ir !== 32'd0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL mid_rst: got req=%b v=%b ir=%h st=%0d exp 0/0/0/0", imem_req, if_valid, ir, dbg_state);
        end
        rst = 1'b0;
        next_cycle;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL mid_restart: got %b/%h exp 1/3000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_stall;
        test_lui;
        test_redirect_hold;
        test_wrap;
        test_latency_redirect;
        test_reset_mid_req;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
